// File: rtl/weight_tile_fifo.sv
// rtl/weight_tile_fifo.sv - tile-aware weight row FIFO with request/burst handshake
module weight_tile_fifo #(
    parameter int MUL_SIZE   = 32,
    parameter int W_BITS     = 8,
    parameter int TILE_ROWS  = 32,
    parameter int TILE_DEPTH = 2
) (
    input  logic                                clk_i,
    input  logic                                rstN_i,
    input  logic [W_BITS-1:0]                   data_i [MUL_SIZE],
    input  logic                                write_en_i,
    input  logic                                sending_data_i,
    input  logic                                read_en_i,
    input  logic                                flush_i,
    input  logic [$clog2(TILE_ROWS+1)-1:0]      tile_rows_i,
    output logic [W_BITS-1:0]                   data_o [MUL_SIZE],
    output logic                                valid_o,
    output logic                                fifo_full_o,
    output logic                                request_data_o,
    output logic                                tile_valid_o,
    output logic [$clog2(TILE_DEPTH+1)-1:0]     tiles_o,
    output logic                                overflow_err_o,
    output logic                                underflow_err_o
);

    localparam int ROWS = TILE_DEPTH * TILE_ROWS;
    localparam int PW   = $clog2(ROWS);
    localparam int CW   = $clog2(ROWS + 1);
    localparam int TRW  = $clog2(TILE_ROWS + 1);
    localparam int TW   = $clog2(TILE_DEPTH + 1);
    localparam int TMAX = (1 << TW) - 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST} state_t;

    logic [W_BITS-1:0] mem [ROWS][MUL_SIZE];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, free_rows, tile_cnt;
    logic [TRW-1:0]    th, th_sat, th_m1, wr_row, rd_row;
    logic              full, empty, wr_attempt, push, pop, tile_inc, tile_dec;
    state_t            state_q, state_d;

    assign full       = (count == CW'(ROWS));
    assign empty      = (count == '0);
    assign free_rows  = CW'(ROWS) - count;
    assign wr_attempt = sending_data_i & write_en_i;
    assign push       = wr_attempt & ~full & ~flush_i;
    assign pop        = read_en_i & ~empty & ~flush_i;
    assign th_m1      = th - TRW'(1);
    assign tile_inc   = push & (wr_row == th_m1);
    assign tile_dec   = pop & (rd_row == th_m1);

    assign valid_o        = ~empty;
    assign fifo_full_o    = full;
    assign request_data_o = (state_q == S_REQ);
    assign tile_valid_o   = (tile_cnt != '0);
    assign tiles_o        = (tile_cnt > CW'(TMAX)) ? TW'(TMAX) : TW'(tile_cnt);

    // Map the requested tile height: zero and oversize values select the full tile.
    always_comb begin
        th_sat = tile_rows_i;
        if (tile_rows_i == '0 || tile_rows_i > TRW'(TILE_ROWS)) th_sat = TRW'(TILE_ROWS);
    end

    // Row storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // First-word fall-through head row, forced to zero while empty.
    always_comb begin
        for (int j = 0; j < MUL_SIZE; j++) data_o[j] = valid_o ? mem[rd_ptr][j] : '0;
    end

    // Pointers, occupancy, tile bookkeeping, tile height and sticky errors.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            wr_row          <= '0;
            rd_row          <= '0;
            tile_cnt        <= '0;
            th              <= TRW'(TILE_ROWS);
            overflow_err_o  <= 1'b0;
            underflow_err_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            wr_row          <= '0;
            rd_row          <= '0;
            tile_cnt        <= '0;
            overflow_err_o  <= 1'b0;
            underflow_err_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                wr_row <= tile_inc ? '0 : wr_row + TRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                rd_row <= tile_dec ? '0 : rd_row + TRW'(1);
            end
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (tile_inc && !tile_dec) tile_cnt <= tile_cnt + CW'(1);
            else if (tile_dec && !tile_inc) tile_cnt <= tile_cnt - CW'(1);
            // Empty with no burst in flight is a clean tile boundary; an
            // outstanding request that has accepted no row yet also qualifies.
            if (empty && state_q != S_BURST) th <= th_sat;
            if (wr_attempt && full) overflow_err_o <= 1'b1;
            if (read_en_i && empty) underflow_err_o <= 1'b1;
        end
    end

    // Request FSM state register.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Request FSM next state: ask for a tile when it fits, stay in burst until it completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (free_rows >= CW'(th)) state_d = S_REQ;
            S_REQ:   if (sending_data_i) state_d = tile_inc ? S_IDLE : S_BURST;
            S_BURST: if (tile_inc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

endmodule

// File: tb/tb_weight_tile_fifo.sv
// tb/tb_weight_tile_fifo.sv - directed self-checking bench for weight_tile_fifo
module tb_weight_tile_fifo;

    localparam int MS = 32;
    localparam int WB = 8;

    logic          clk_i = 1'b0;
    logic          rstN_i;
    logic [WB-1:0] data_i [MS];
    logic          write_en_i, sending_data_i, read_en_i, flush_i;
    logic [5:0]    tile_rows_i;
    logic [WB-1:0] data_o [MS];
    logic          valid_o, fifo_full_o, request_data_o, tile_valid_o;
    logic [1:0]    tiles_o;
    logic          overflow_err_o, underflow_err_o;
    logic [MS*WB-1:0] head_flat;
    logic [7:0]    status;
    int            n_pass = 0;
    int            n_total = 0;

    weight_tile_fifo dut (
        .clk_i(clk_i), .rstN_i(rstN_i), .data_i(data_i), .write_en_i(write_en_i),
        .sending_data_i(sending_data_i), .read_en_i(read_en_i), .flush_i(flush_i),
        .tile_rows_i(tile_rows_i), .data_o(data_o), .valid_o(valid_o),
        .fifo_full_o(fifo_full_o), .request_data_o(request_data_o),
        .tile_valid_o(tile_valid_o), .tiles_o(tiles_o),
        .overflow_err_o(overflow_err_o), .underflow_err_o(underflow_err_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int j = 0; j < MS; j++) head_flat[j*WB +: WB] = data_o[j];
    end
    assign status = {valid_o, fifo_full_o, request_data_o, tile_valid_o, tiles_o,
                     overflow_err_o, underflow_err_o};

    function automatic logic [MS*WB-1:0] exp_row(input int id);
        logic [MS*WB-1:0] r;
        for (int j = 0; j < MS; j++) r[j*WB +: WB] = 8'(id + 3 * j);
        return r;
    endfunction

    task automatic drive_row(input int id);
        for (int j = 0; j < MS; j++) data_i[j] = 8'(id + 3 * j);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstN_i = 1'b0; write_en_i = 0; sending_data_i = 0; read_en_i = 0; flush_i = 0;
        tile_rows_i = 6'd4; drive_row(250);
        repeat (3) tick();
        n_total++; if (status !== 8'b0) $display("FAIL reset_status got %b want %b", status, 8'b0); else n_pass++;
        n_total++; if (head_flat !== '0) $display("FAIL reset_data got %h want 0", head_flat); else n_pass++;
        rstN_i = 1'b1;
        tick();
        n_total++; if (request_data_o !== 1'b1) $display("FAIL reset_req_rise got %b want 1", request_data_o); else n_pass++;
    endtask

    task automatic test_tile_burst();
        sending_data_i = 1; write_en_i = 1;
        drive_row(0); tick();
        n_total++; if (status !== 8'b1000_0000) $display("FAIL burst_first got %b want %b", status, 8'b1000_0000); else n_pass++;
        n_total++; if (head_flat !== exp_row(0)) $display("FAIL burst_head0 got %h want %h", head_flat, exp_row(0)); else n_pass++;
        drive_row(1); tick();
        drive_row(2); tick();
        n_total++; if (tile_valid_o !== 1'b0) $display("FAIL burst_tv_early got %b want 0", tile_valid_o); else n_pass++;
        drive_row(3); tick();
        n_total++; if (status !== 8'b1001_0100) $display("FAIL burst_done got %b want %b", status, 8'b1001_0100); else n_pass++;
        sending_data_i = 0; write_en_i = 0;
        tick();
        n_total++; if (status !== 8'b1011_0100) $display("FAIL burst_rereq got %b want %b", status, 8'b1011_0100); else n_pass++;
        n_total++; if (head_flat !== exp_row(0)) $display("FAIL burst_head_keep got %h want %h", head_flat, exp_row(0)); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        sending_data_i = 1; write_en_i = 1;
        for (int i = 4; i < 64; i++) begin
            drive_row(i); tick();
        end
        n_total++; if (fifo_full_o !== 1'b1) $display("FAIL fill_full got %b want 1", fifo_full_o); else n_pass++;
        n_total++; if (overflow_err_o !== 1'b0) $display("FAIL fill_ovf_clear got %b want 0", overflow_err_o); else n_pass++;
        n_total++; if (request_data_o !== 1'b0) $display("FAIL fill_req got %b want 0", request_data_o); else n_pass++;
        drive_row(200); tick();
        n_total++; if ({fifo_full_o, overflow_err_o, request_data_o} !== 3'b110) $display("FAIL ovf_push got %b want 110", {fifo_full_o, overflow_err_o, request_data_o}); else n_pass++;
        n_total++; if (head_flat !== exp_row(0)) $display("FAIL ovf_head got %h want %h", head_flat, exp_row(0)); else n_pass++;
        drive_row(201); read_en_i = 1; tick();
        n_total++; if ({fifo_full_o, overflow_err_o} !== 2'b01) $display("FAIL ovf_pushpop got %b want 01", {fifo_full_o, overflow_err_o}); else n_pass++;
        n_total++; if (head_flat !== exp_row(1)) $display("FAIL ovf_pushpop_head got %h want %h", head_flat, exp_row(1)); else n_pass++;
        sending_data_i = 0; write_en_i = 0;
        repeat (60) tick();
        n_total++; if (head_flat !== exp_row(61)) $display("FAIL drain_head got %h want %h", head_flat, exp_row(61)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        sending_data_i = 1; write_en_i = 1; read_en_i = 1;
        for (int k = 0; k < 20; k++) begin
            drive_row(64 + k); tick();
            n_total++; if (head_flat !== exp_row(62 + k)) $display("FAIL b2b_head_%0d got %h want %h", k, head_flat, exp_row(62 + k)); else n_pass++;
        end
        sending_data_i = 0; write_en_i = 0;
        tick();
        n_total++; if (head_flat !== exp_row(82)) $display("FAIL b2b_tail0 got %h want %h", head_flat, exp_row(82)); else n_pass++;
        tick();
        n_total++; if (head_flat !== exp_row(83)) $display("FAIL b2b_tail1 got %h want %h", head_flat, exp_row(83)); else n_pass++;
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL b2b_empty got %b want 0", valid_o); else n_pass++;
        read_en_i = 0;
    endtask

    task automatic test_underflow_flush();
        sending_data_i = 1; write_en_i = 1; read_en_i = 1; drive_row(100);
        tick();
        sending_data_i = 0; write_en_i = 0; read_en_i = 0;
        n_total++; if ({underflow_err_o, overflow_err_o, valid_o} !== 3'b111) $display("FAIL unf_flags got %b want 111", {underflow_err_o, overflow_err_o, valid_o}); else n_pass++;
        n_total++; if (head_flat !== exp_row(100)) $display("FAIL unf_head got %h want %h", head_flat, exp_row(100)); else n_pass++;
        flush_i = 1; tick(); flush_i = 0;
        n_total++; if (status !== 8'b0) $display("FAIL flush_status got %b want %b", status, 8'b0); else n_pass++;
        tick();
        n_total++; if (request_data_o !== 1'b1) $display("FAIL flush_rereq got %b want 1", request_data_o); else n_pass++;
    endtask

    task automatic test_tile_height();
        sending_data_i = 1; write_en_i = 1;
        for (int i = 0; i < 4; i++) begin drive_row(110 + i); tick(); end
        sending_data_i = 0; write_en_i = 0; tile_rows_i = 6'd8;
        repeat (2) tick();
        sending_data_i = 1; write_en_i = 1;
        for (int i = 0; i < 4; i++) begin drive_row(114 + i); tick(); end
        sending_data_i = 0; write_en_i = 0;
        n_total++; if (tiles_o !== 2'd2) $display("FAIL th_hold got %0d want 2", tiles_o); else n_pass++;
        read_en_i = 1;
        repeat (8) tick();
        read_en_i = 0;
        n_total++; if ({valid_o, tiles_o} !== 3'b000) $display("FAIL th_drain got %b want 000", {valid_o, tiles_o}); else n_pass++;
        tick();
        sending_data_i = 1; write_en_i = 1;
        for (int i = 0; i < 7; i++) begin drive_row(120 + i); tick(); end
        n_total++; if (tile_valid_o !== 1'b0) $display("FAIL th8_early got %b want 0", tile_valid_o); else n_pass++;
        drive_row(127); tick();
        sending_data_i = 0; write_en_i = 0;
        n_total++; if ({tile_valid_o, tiles_o} !== 3'b101) $display("FAIL th8_done got %b want 101", {tile_valid_o, tiles_o}); else n_pass++;
        n_total++; if (head_flat !== exp_row(120)) $display("FAIL th8_head got %h want %h", head_flat, exp_row(120)); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        flush_i = 1; tick(); flush_i = 0;
        tile_rows_i = 6'd0;
        tick();
        sending_data_i = 1; write_en_i = 1;
        for (int i = 0; i < 5; i++) begin drive_row(130 + i); tick(); end
        sending_data_i = 0; write_en_i = 0;
        repeat (2) tick();
        n_total++; if ({valid_o, request_data_o} !== 2'b10) $display("FAIL pause_req got %b want 10", {valid_o, request_data_o}); else n_pass++;
        rstN_i = 1'b0;
        #1;
        n_total++; if (status !== 8'b0) $display("FAIL midrst_status got %b want %b", status, 8'b0); else n_pass++;
        n_total++; if (head_flat !== '0) $display("FAIL midrst_data got %h want 0", head_flat); else n_pass++;
        tick();
        rstN_i = 1'b1;
        tick();
        n_total++; if (request_data_o !== 1'b1) $display("FAIL midrst_rereq got %b want 1", request_data_o); else n_pass++;
        sending_data_i = 1; write_en_i = 1;
        for (int i = 0; i < 31; i++) begin drive_row(140 + i); tick(); end
        n_total++; if (tile_valid_o !== 1'b0) $display("FAIL th32_early got %b want 0", tile_valid_o); else n_pass++;
        drive_row(171); tick();
        sending_data_i = 0; write_en_i = 0;
        n_total++; if ({tile_valid_o, tiles_o} !== 3'b101) $display("FAIL th32_done got %b want 101", {tile_valid_o, tiles_o}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tile_burst();
        test_fill_overflow();
        test_back_to_back();
        test_underflow_flush();
        test_tile_height();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
